spike_rate_encoder: RTL and testbench

Converts a frame of N_CH unsigned 8-bit input intensities into N_CH parallel spike trains over a programmable number of timesteps. Stochastic rate coding uses per-channel LFSRs; a compile-time option switches to deterministic phase-accumulator coding. The block sits upstream of the LIF neuron array and drives its per-timestep spike input vector through a valid/ready handshake, one handshake per simulation timestep.

---
 rtl/spike_rate_encoder_if.sv | 21 ++
 rtl/spike_rate_encoder.sv | 126 ++++++++++++
 tb/tb_spike_rate_encoder.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_rate_encoder_if.sv
// Spike vector handshake from the encoder to the neuron array.
// Master drives the vector and valid; slave answers with ready.
interface spike_rate_encoder_if #(
  parameter int N_CH = 8
);
  logic [N_CH-1:0] spike_out;
  logic            spike_valid;
  logic            step_ready;

  modport master (
    output spike_out,
    output spike_valid,
    input  step_ready
  );

  modport slave (
    input  spike_out,
    input  spike_valid,
    output step_ready
  );
endinterface

// File: rtl/spike_rate_encoder.sv
// Frame of pixel intensities to per-timestep spike vectors.
// Define SPIKE_ENC_DETERMINISTIC_EN for phase-accumulator coding.
module spike_rate_encoder #(
  parameter int          N_CH = 8,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [8*N_CH-1:0]   pixel_in,
  input  logic [7:0]          num_steps,
  spike_rate_encoder_if.master step,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [8*N_CH-1:0] pix_q;
  logic [7:0]        steps_q;
  logic [7:0]        cnt_q;
  logic [N_CH-1:0]   spk;
  logic              load;
  logic              hs;
  logic              last;

  assign load = (state == IDLE) && start;
  assign hs   = step.spike_valid && step.step_ready;
  assign last = (cnt_q == steps_q - 8'd1);

`ifndef SPIKE_ENC_DETERMINISTIC_EN
  function automatic logic [15:0] seed_of(input int i);
    logic [15:0] s;
    s = SEED ^ 16'(i * 32'h1F35);
    return (s == 16'd0) ? 16'h0001 : s;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start)
              state_nx = (num_steps == 8'd0) ? DONE : EMIT;
      EMIT: if (hs && last)
              state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy             = 1'b0;
    done             = 1'b0;
    step.spike_valid = 1'b0;
    step.spike_out   = '0;
    unique case (state)
      EMIT: begin
        busy             = 1'b1;
        step.spike_valid = 1'b1;
        step.spike_out   = spk;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_q   <= '0;
      steps_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      pix_q   <= pixel_in;
      steps_q <= num_steps;
      cnt_q   <= '0;
    end else if (hs) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [7:0] pix;
    assign pix = pix_q[8*i +: 8];
`ifdef SPIKE_ENC_DETERMINISTIC_EN
    logic [7:0] acc;
    logic [8:0] sum;
    // Carry-out marks each wrap of the phase, giving floor(p*n/256) spikes
    assign sum    = {1'b0, acc} + {1'b0, pix};
    assign spk[i] = sum[8];

    always_ff @(posedge clk) begin
      if (reset)     acc <= '0;
      else if (load) acc <= '0;
      else if (hs)   acc <= sum[7:0];
    end
`else
    localparam logic [15:0] S = seed_of(i);
    logic [15:0] lfsr;
    logic [15:0] lfsr_nx;
    assign lfsr_nx = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400)
                             : (lfsr >> 1);
    assign spk[i]  = (pix != 8'd0) && (lfsr[7:0] <= pix);

    always_ff @(posedge clk) begin
      if (reset)     lfsr <= S;
      else if (load) lfsr <= S;
      else if (hs)   lfsr <= lfsr_nx;
    end
`endif
  end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Randomised self-checking bench for spike_rate_encoder.
// Reference model derives every vector from pixel values and step index.
module tb_spike_rate_encoder;
  localparam int          N_CH = 8;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          BUDGET = 2000;

  typedef logic [7:0] pix_t [N_CH];

  logic                clk;
  logic                reset;
  logic                start;
  logic [8*N_CH-1:0]   pixel_in;
  logic [7:0]          num_steps;
  logic                busy;
  logic                done;

  spike_rate_encoder_if #(.N_CH(N_CH)) sif ();

  spike_rate_encoder #(.N_CH(N_CH), .SEED(SEED)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pixel_in  (pixel_in),
    .num_steps (num_steps),
    .step      (sif.master),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [N_CH-1:0] got_q[$];
  int stall_bad;
  int valid_cycles;
  int frame_ticks;
  bit done_ok;
  bit idle_ok;
  bit timed_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected spike vector on step k (k=0 is the first vector of a frame)
  function automatic logic [N_CH-1:0] model_vec(input pix_t p, input int k);
    logic [N_CH-1:0] v;
    v = '0;
    for (int c = 0; c < N_CH; c++) begin
`ifdef SPIKE_ENC_DETERMINISTIC_EN
      int a, b;
      a = (k * int'(p[c])) / 256;
      b = ((k + 1) * int'(p[c])) / 256;
      v[c] = (b > a);
`else
      int s, r;
      s = int'(SEED) ^ ((c * 'h1F35) & 'hFFFF);
      if (s == 0) s = 1;
      for (int j = 0; j < k; j++) begin
        if ((s & 1) != 0) s = (s >> 1) ^ 'hB400;
        else              s = s >> 1;
      end
      r = s & 'hFF;
      v[c] = (p[c] != 8'd0) && (r <= int'(p[c]));
`endif
    end
    return v;
  endfunction

  task automatic run_frame(input pix_t p, input logic [7:0] steps,
                           input bit rnd_ready, input bit inject);
    logic [N_CH-1:0] prev;
    bit stalled;
    bit last_hs;
    int cyc;
    got_q.delete();
    stall_bad = 0;
    valid_cycles = 0;
    done_ok = 0;
    idle_ok = 0;
    timed_out = 0;
    prev = '0;
    for (int i = 0; i < N_CH; i++) pixel_in[8*i +: 8] = p[i];
    num_steps = steps;
    start = 1'b1;
    step_ready_set(1'b0);
    tick();
    frame_ticks = 1;
    start = 1'b0;
    stalled = 0;
    last_hs = (steps == 8'd0);
    cyc = 0;
    while (!done && cyc < BUDGET) begin
      if (sif.spike_valid) begin
        valid_cycles++;
        if (stalled && sif.spike_out !== prev) stall_bad++;
        step_ready_set(rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        if (inject) begin
          start = 1'($urandom_range(0, 1));
          pixel_in = {$urandom, $urandom};
          num_steps = 8'($urandom);
        end
        if (sif.step_ready) got_q.push_back(sif.spike_out);
        stalled = !sif.step_ready;
        last_hs = sif.step_ready;
        prev = sif.spike_out;
      end else begin
        if (sif.spike_out !== '0) stall_bad++;
        last_hs = 0;
      end
      tick();
      frame_ticks++;
      cyc++;
    end
    timed_out = (cyc >= BUDGET);
    done_ok = done && busy && !sif.spike_valid && last_hs;
    start = 1'b0;
    step_ready_set(1'b0);
    tick();
    frame_ticks++;
    idle_ok = !busy && !done && !sif.spike_valid;
  endtask

  task automatic step_ready_set(input logic v);
    sif.step_ready = v;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    pixel_in = '0;
    num_steps = '0;
    step_ready_set(1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks += 4;
    if (sif.spike_out !== '0) begin
      errors++; $display("FAIL reset_spike: got %h want 0", sif.spike_out);
    end
    if (sif.spike_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", sif.spike_valid);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    if (done !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %b want 0", done);
    end
  endtask

  task automatic test_zero_len();
    pix_t p;
    for (int i = 0; i < N_CH; i++) p[i] = 8'($urandom);
    run_frame(p, 8'd0, 1'b0, 1'b0);
    checks += 4;
    if (!done_ok || timed_out) begin
      errors++; $display("FAIL zero_done: got %b want 1", done_ok);
    end
    if (valid_cycles != 0) begin
      errors++; $display("FAIL zero_valid: got %0d want 0", valid_cycles);
    end
    if (frame_ticks != 2) begin
      errors++; $display("FAIL zero_time: got %0d want 2", frame_ticks);
    end
    if (!idle_ok) begin
      errors++; $display("FAIL zero_idle: got 0 want 1");
    end
  endtask

  task automatic test_extremes();
    pix_t p;
    logic [N_CH-1:0] e;
    int bad;
    for (int i = 0; i < N_CH; i++) p[i] = (i % 2 == 1) ? 8'd255 : 8'd0;
    run_frame(p, 8'd16, 1'b0, 1'b0);
    bad = 0;
    for (int k = 0; k < got_q.size(); k++) begin
      e = model_vec(p, k);
`ifndef SPIKE_ENC_DETERMINISTIC_EN
      e = 8'hAA;
`endif
      if (got_q[k] !== e) begin
        bad++;
        $display("FAIL ext_vec[%0d]: got %h want %h", k, got_q[k], e);
      end
    end
    checks += 5;
    if (bad != 0) errors++;
    if (got_q.size() != 16) begin
      errors++; $display("FAIL ext_count: got %0d want 16", got_q.size());
    end
    if (valid_cycles != 16) begin
      errors++; $display("FAIL ext_valid: got %0d want 16", valid_cycles);
    end
    if (!done_ok || timed_out) begin
      errors++; $display("FAIL ext_done: got %b want 1", done_ok);
    end
    if (frame_ticks != 18 || !idle_ok) begin
      errors++; $display("FAIL ext_time: got %0d want 18", frame_ticks);
    end
  endtask

  task automatic test_backpressure();
    pix_t p;
    logic [N_CH-1:0] ref_q[$];
    int bad;
    for (int i = 0; i < N_CH; i++) p[i] = 8'd128;
    run_frame(p, 8'd10, 1'b0, 1'b0);
    ref_q = got_q;
    run_frame(p, 8'd10, 1'b1, 1'b1);
    bad = 0;
    for (int k = 0; k < got_q.size() && k < ref_q.size(); k++) begin
      if (got_q[k] !== ref_q[k] || got_q[k] !== model_vec(p, k)) begin
        bad++;
        $display("FAIL bp_vec[%0d]: got %h want %h", k, got_q[k],
                 model_vec(p, k));
      end
    end
    checks += 5;
    if (bad != 0) errors++;
    if (got_q.size() != 10) begin
      errors++; $display("FAIL bp_count: got %0d want 10", got_q.size());
    end
    if (stall_bad != 0) begin
      errors++; $display("FAIL bp_stable: got %0d want 0", stall_bad);
    end
    if (!done_ok || timed_out) begin
      errors++; $display("FAIL bp_done: got %b want 1", done_ok);
    end
    if (!idle_ok) begin
      errors++; $display("FAIL bp_idle: got 0 want 1");
    end
  endtask

  task automatic test_random();
    pix_t p;
    logic [7:0] n;
    int bad;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < N_CH; i++) begin
        case ($urandom_range(0, 3))
          0: p[i] = 8'd0;
          1: p[i] = 8'd255;
          default: p[i] = 8'($urandom);
        endcase
      end
      n = 8'($urandom_range(1, 40));
      run_frame(p, n, 1'b1, 1'b0);
      bad = 0;
      for (int k = 0; k < got_q.size(); k++) begin
        if (got_q[k] !== model_vec(p, k)) begin
          bad++;
          $display("FAIL rnd_vec[%0d.%0d]: got %h want %h", f, k,
                   got_q[k], model_vec(p, k));
        end
      end
      checks += 4;
      if (bad != 0) errors++;
      if (got_q.size() != int'(n)) begin
        errors++;
        $display("FAIL rnd_count[%0d]: got %0d want %0d", f, got_q.size(), n);
      end
      if (stall_bad != 0) begin
        errors++; $display("FAIL rnd_stable[%0d]: got %0d want 0", f, stall_bad);
      end
      if (!done_ok || !idle_ok || timed_out) begin
        errors++; $display("FAIL rnd_done[%0d]: got %b want 1", f, done_ok);
      end
    end
  endtask

  task automatic test_reset_mid();
    pix_t p;
    logic [N_CH-1:0] rec[5];
    int bad;
    for (int i = 0; i < N_CH; i++) p[i] = 8'($urandom);
    for (int i = 0; i < N_CH; i++) pixel_in[8*i +: 8] = p[i];
    num_steps = 8'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    step_ready_set(1'b1);
    for (int k = 0; k < 5; k++) begin
      rec[k] = sif.spike_out;
      tick();
    end
    reset = 1'b1;
    step_ready_set(1'b0);
    tick();
    checks += 2;
    if (busy !== 1'b0 || sif.spike_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b valid=%b done=%b want 0 0 0",
               busy, sif.spike_valid, done);
    end
    reset = 1'b0;
    tick();
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_nodone: got done=%b busy=%b want 0 0",
                         done, busy);
    end
    run_frame(p, 8'd20, 1'b0, 1'b0);
    bad = 0;
    for (int k = 0; k < 5 && k < got_q.size(); k++) begin
      if (got_q[k] !== rec[k] || rec[k] !== model_vec(p, k)) begin
        bad++;
        $display("FAIL mid_repeat[%0d]: got %h want %h", k, rec[k],
                 model_vec(p, k));
      end
    end
    checks += 2;
    if (bad != 0) errors++;
    if (got_q.size() != 20 || !done_ok) begin
      errors++; $display("FAIL mid_refr: got %0d want 20", got_q.size());
    end
  endtask

`ifdef SPIKE_ENC_DETERMINISTIC_EN
  task automatic test_deterministic();
    pix_t p;
    int want[N_CH];
    int cnt[N_CH];
    int odd_bad;
    p = '{8'd0, 8'd1, 8'd64, 8'd128, 8'd200, 8'd254, 8'd255, 8'd255};
    want = '{0, 0, 63, 127, 199, 253, 254, 254};
    run_frame(p, 8'd255, 1'b0, 1'b0);
    for (int c = 0; c < N_CH; c++) cnt[c] = 0;
    odd_bad = 0;
    for (int k = 0; k < got_q.size(); k++) begin
      for (int c = 0; c < N_CH; c++) if (got_q[k][c]) cnt[c]++;
      if (got_q[k][3] !== 1'(k % 2)) odd_bad++;
    end
    for (int c = 0; c < N_CH; c++) begin
      checks++;
      if (cnt[c] != want[c]) begin
        errors++;
        $display("FAIL det_count[%0d]: got %0d want %0d", c, cnt[c], want[c]);
      end
    end
    checks += 2;
    if (odd_bad != 0) begin
      errors++; $display("FAIL det_odd: got %0d bad steps want 0", odd_bad);
    end
    if (got_q.size() != 255 || !done_ok) begin
      errors++; $display("FAIL det_len: got %0d want 255", got_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_len();
    test_extremes();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef SPIKE_ENC_DETERMINISTIC_EN
    test_deterministic();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
